multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the RV32I core.
- Sequences each instruction through fetch, decode, execute, memory and writeback, using the decoder's control outputs (reg_write, mem_read, mem_write, branch).
- Drives the register-enable strobes for the IR, PC, ALU-out and register file, and the handshakes to instruction and data memory.
- Sits between the decoder and the datapath registers; owns the only state that says which phase the core is in.

---
 rtl/core_ctrl_pkg.sv | 42 ++++
 rtl/ctrl_wait_timer.sv | 34 +++
 rtl/multicycle_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared control definitions for the RV32I core: controller states,
// opcode map and immediate-format codes used by controller and decoder.
package core_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_ERR     = 3'd7
    } state_e;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
    } dec_flags_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    function automatic logic is_wait_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEM);
    endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Memory-handshake wait counter; flags expiry when the limit is reached
// without a ready in the same cycle.
module ctrl_wait_timer #(
    parameter int TIMEOUT_CYC = 255,
    parameter int TO_W        = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic busy,
    input  logic ready,
    output logic expired
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_CYC);

    logic [TO_W-1:0] cnt_q, cnt_d;

    // Any cycle that is not an unanswered request clears the count, so
    // every entry into a wait state starts from zero.
    always_comb begin
        cnt_d   = '0;
        expired = 1'b0;
        if (busy && !ready) begin
            cnt_d   = cnt_q + TO_W'(1);
            expired = (cnt_q == LIMIT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer for the RV32I core.
// Define CTRL_PERF_CNT_EN to build the cycle and retired-instruction counters.
module multicycle_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int TO_W        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        imem_req,
    input  logic        imem_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    input  logic        dec_reg_write,
    input  logic        dec_mem_read,
    input  logic        dec_mem_write,
    input  logic        dec_branch,
    input  logic        br_taken,
    output logic        ir_we,
    output logic        alu_out_we,
    output logic        rf_we,
    output logic        pc_we,
    output logic        pc_sel_tgt,
    output logic        retire,
    output logic        err,
    output logic [2:0]  state_o,
    output logic [31:0] cyc_cnt,
    output logic [31:0] instret_cnt
);

    state_e     state_q, state_d;
    dec_flags_t flags_q, flags_d;
    logic       taken_q, taken_d;
    logic       taken_now;
    logic       wait_busy, wait_ready, wait_expired;
    state_e     next_fetch;

    assign wait_busy  = is_wait_state(state_q);
    assign wait_ready = (state_q == S_FETCH) ? imem_ready : dmem_ready;
    assign next_fetch = run ? S_FETCH : S_IDLE;

    ctrl_wait_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_W        (TO_W)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .busy    (wait_busy),
        .ready   (wait_ready),
        .expired (wait_expired)
    );

    always_comb begin
        state_d    = state_q;
        flags_d    = flags_q;
        taken_d    = taken_q;
        taken_now  = 1'b0;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_we      = 1'b0;
        alu_out_we = 1'b0;
        rf_we      = 1'b0;
        pc_we      = 1'b0;
        pc_sel_tgt = 1'b0;
        retire     = 1'b0;
        err        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_expired) begin
                    state_d = S_ERR;
                end
            end
            S_DECODE: begin
                flags_d.reg_write = dec_reg_write;
                flags_d.mem_read  = dec_mem_read;
                flags_d.mem_write = dec_mem_write;
                flags_d.branch    = dec_branch;
                state_d           = S_EXECUTE;
            end
            S_EXECUTE: begin
                alu_out_we = 1'b1;
                taken_now  = flags_q.branch & br_taken;
                taken_d    = taken_now;
                if (flags_q.mem_read || flags_q.mem_write) begin
                    state_d = S_MEM;
                end else if (flags_q.reg_write) begin
                    state_d = S_WB;
                end else begin
                    pc_we      = 1'b1;
                    pc_sel_tgt = taken_now;
                    retire     = 1'b1;
                    state_d    = next_fetch;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                // read+write together is illegal; it degrades to a load
                dmem_we  = flags_q.mem_write & ~flags_q.mem_read;
                if (dmem_ready) begin
                    if (flags_q.mem_read) begin
                        state_d = S_WB;
                    end else begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = next_fetch;
                    end
                end else if (wait_expired) begin
                    state_d = S_ERR;
                end
            end
            S_WB: begin
                rf_we      = 1'b1;
                pc_we      = 1'b1;
                pc_sel_tgt = taken_q;
                retire     = 1'b1;
                state_d    = next_fetch;
            end
            S_ERR: begin
                err = 1'b1;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            flags_q <= '0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            taken_q <= taken_d;
        end
    end

    assign state_o = state_q;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] ins_q, ins_d;

    always_comb begin
        cyc_d = cyc_q;
        ins_d = ins_q;
        if (state_q != S_IDLE && state_q != S_ERR) cyc_d = cyc_q + 32'd1;
        if (retire) ins_d = ins_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= '0;
            ins_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            ins_q <= ins_d;
        end
    end

    assign cyc_cnt     = cyc_q;
    assign instret_cnt = ins_q;
`else
    assign cyc_cnt     = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed instruction sequences
// push expected strobe events; a negedge monitor pops and compares them.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        dec_reg_write = 1'b0;
    logic        dec_mem_read = 1'b0;
    logic        dec_mem_write = 1'b0;
    logic        dec_branch = 1'b0;
    logic        br_taken = 1'b0;
    logic        imem_req, dmem_req, dmem_we;
    logic        ir_we, alu_out_we, rf_we, pc_we, pc_sel_tgt, retire, err;
    logic [2:0]  state_o;
    logic [31:0] cyc_cnt, instret_cnt;

    always #5 clk = ~clk;

    multicycle_ctrl #(
        .TIMEOUT_CYC (4),
        .TO_W        (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .imem_req      (imem_req),
        .imem_ready    (imem_ready),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_ready    (dmem_ready),
        .dec_reg_write (dec_reg_write),
        .dec_mem_read  (dec_mem_read),
        .dec_mem_write (dec_mem_write),
        .dec_branch    (dec_branch),
        .br_taken      (br_taken),
        .ir_we         (ir_we),
        .alu_out_we    (alu_out_we),
        .rf_we         (rf_we),
        .pc_we         (pc_we),
        .pc_sel_tgt    (pc_sel_tgt),
        .retire        (retire),
        .err           (err),
        .state_o       (state_o),
        .cyc_cnt       (cyc_cnt),
        .instret_cnt   (instret_cnt)
    );

    int total = 0;
    int passed = 0;

    task automatic check(input string n, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", n, act, exp);
    endtask

    typedef struct {
        string      name;
        logic [11:0] vec;
        int         gap;
    } ev_t;

    ev_t sb[$];
    ev_t mon_e;

    // {ir_we, alu_out_we, rf_we, pc_we, pc_sel_tgt, retire,
    //  dmem_req, dmem_we, err, state}
    function automatic logic [11:0] V(input logic ir, alu, rf, pw, sel,
                                      ret, dr, dw, er,
                                      input logic [2:0] st);
        return {ir, alu, rf, pw, sel, ret, dr, dw, er, st};
    endfunction

    task automatic expect_ev(input string n, input logic [11:0] v,
                             input int g);
        ev_t e;
        e.name = n;
        e.vec  = v;
        e.gap  = g;
        sb.push_back(e);
    endtask

    // Memory responder: ready after ilat/dlat unanswered request cycles.
    int ilat = 0;
    int dlat = 0;
    int icnt = 0;
    int dcnt = 0;

    always begin
        @(posedge clk);
        #1;
        if (!rst_n || !imem_req) begin
            icnt = 0;
            imem_ready = 1'b0;
        end else begin
            imem_ready = (icnt >= ilat);
            icnt++;
        end
        if (!rst_n || !dmem_req) begin
            dcnt = 0;
            dmem_ready = 1'b0;
        end else begin
            dmem_ready = (dcnt >= dlat);
            dcnt++;
        end
    end

    // Gap = cycles since the previous event, or since the last IDLE cycle.
    int          since = 0;
    int          retire_seen = 0;
    logic        err_prev = 1'b0;
    logic [11:0] actv;

    always @(negedge clk) begin
        if (!rst_n) begin
            since = 0;
            err_prev = 1'b0;
        end else if (state_o == 3'd0) begin
            since = 0;
        end else begin
            since++;
            if (ir_we || alu_out_we || rf_we || pc_we ||
                (dmem_req && dmem_ready) || (err && !err_prev)) begin
                actv = {ir_we, alu_out_we, rf_we, pc_we, pc_sel_tgt,
                        retire, dmem_req, dmem_we, err, state_o};
                if (retire) retire_seen++;
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_event: got %0h expected none",
                             actv);
                end else begin
                    mon_e = sb.pop_front();
                    check({mon_e.name, "_vec"}, 32'(actv), 32'(mon_e.vec));
                    check({mon_e.name, "_gap"}, since, mon_e.gap);
                end
                since = 0;
            end
            err_prev = err;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic set_dec(input logic rw, mr, mw, br, tk);
        dec_reg_write = rw;
        dec_mem_read  = mr;
        dec_mem_write = mw;
        dec_branch    = br;
        br_taken      = tk;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (state_o != 3'd0 && n < 300) begin
            step(1);
            n++;
        end
        check({tag, "_idle"}, 32'(state_o), 32'd0);
        check({tag, "_drained"}, sb.size(), 0);
    endtask

    task automatic run_one(input string tag);
        run = 1'b1;
        step(1);
        run = 1'b0;
        wait_idle(tag);
    endtask

    task automatic exp_fetch(input string n, input int g);
        expect_ev({n, "_fetch"}, V(1,0,0,0,0,0,0,0,0,3'd1), g);
    endtask

    task automatic exp_exec(input string n, input logic pw, sel);
        expect_ev({n, "_exec"}, V(0,1,0,pw,sel,pw,0,0,0,3'd3), 2);
    endtask

    task automatic exp_wb(input string n, input logic sel);
        expect_ev({n, "_wb"}, V(0,0,1,1,sel,1,0,0,0,3'd5), 1);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic run_burst(input string tag, input int n_ins);
        int base;
        int n;
        base = retire_seen;
        n = 0;
        for (int i = 0; i < n_ins; i++) begin
            exp_fetch(tag, 1);
            exp_exec(tag, 1'b0, 1'b0);
            exp_wb(tag, 1'b0);
        end
        run = 1'b1;
        while (retire_seen - base < n_ins && n < 2000) begin
            step(1);
            n++;
        end
        run = 1'b0;
        wait_idle(tag);
        check({tag, "_retires"}, retire_seen - base, n_ins);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int n;

        step(3);
        check("rst_outputs",
              32'({imem_req, dmem_req, dmem_we, ir_we, alu_out_we, rf_we,
                   pc_we, pc_sel_tgt, retire, err, state_o}), 32'd0);
        rst_n = 1'b1;
        step(3);
        check("idle_hold", 32'(state_o), 32'd0);

        set_dec(1, 0, 0, 0, 0);
        exp_fetch("addi", 1);
        exp_exec("addi", 1'b0, 1'b0);
        exp_wb("addi", 1'b0);
        run_one("addi");

        dlat = 3;
        set_dec(1, 1, 0, 0, 0);
        exp_fetch("lw", 1);
        exp_exec("lw", 1'b0, 1'b0);
        expect_ev("lw_mem", V(0,0,0,0,0,0,1,0,0,3'd4), 4);
        exp_wb("lw", 1'b0);
        base = retire_seen;
        run_one("lw");
        check("lw_retires", retire_seen - base, 1);

        dlat = 0;
        set_dec(0, 0, 1, 0, 0);
        exp_fetch("sw", 1);
        exp_exec("sw", 1'b0, 1'b0);
        expect_ev("sw_mem", V(0,0,0,1,0,1,1,1,0,3'd4), 1);
        run_one("sw");

        set_dec(0, 0, 0, 1, 1);
        exp_fetch("beq", 1);
        exp_exec("beq", 1'b1, 1'b1);
        run_one("beq");

        set_dec(0, 0, 0, 1, 0);
        exp_fetch("bne", 1);
        exp_exec("bne", 1'b1, 1'b0);
        run_one("bne");

        set_dec(1, 0, 0, 1, 1);
        exp_fetch("jal", 1);
        exp_exec("jal", 1'b0, 1'b0);
        exp_wb("jal", 1'b1);
        run_one("jal");

        set_dec(1, 1, 1, 0, 0);
        exp_fetch("rdwr", 1);
        exp_exec("rdwr", 1'b0, 1'b0);
        expect_ev("rdwr_mem", V(0,0,0,0,0,0,1,0,0,3'd4), 1);
        exp_wb("rdwr", 1'b0);
        run_one("rdwr");

        ilat = 4;
        set_dec(0, 0, 0, 1, 0);
        exp_fetch("limit", 5);
        exp_exec("limit", 1'b1, 1'b0);
        run_one("limit");
        check("limit_no_err", 32'(err), 32'd0);

        ilat = 1000;
        expect_ev("tmo_err", V(0,0,0,0,0,0,0,0,1,3'd7), 6);
        run = 1'b1;
        step(1);
        run = 1'b0;
        step(12);
        check("tmo_state", 32'(state_o), 32'd7);
        check("tmo_err_held", 32'(err), 32'd1);
        check("tmo_req_drop", 32'(imem_req), 32'd0);
        check("tmo_drained", sb.size(), 0);
        ilat = 0;
        reset_dut();
        check("tmo_cleared", 32'({err, state_o}), 32'd0);

        dlat = 1000;
        set_dec(1, 1, 0, 0, 0);
        exp_fetch("rstmem", 1);
        exp_exec("rstmem", 1'b0, 1'b0);
        run = 1'b1;
        step(1);
        run = 1'b0;
        n = 0;
        while (state_o != 3'd4 && n < 50) begin
            step(1);
            n++;
        end
        step(2);
        check("rstmem_req", 32'(dmem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmem_async", 32'({dmem_req, state_o}), 32'd0);
        check("rstmem_drained", sb.size(), 0);
        step(1);
        rst_n = 1'b1;
        dlat = 0;
        step(1);
        set_dec(1, 0, 0, 0, 0);
        exp_fetch("restart", 1);
        exp_exec("restart", 1'b0, 1'b0);
        exp_wb("restart", 1'b0);
        run_one("restart");

        reset_dut();
        set_dec(1, 0, 0, 0, 0);
        run_burst("b10", 10);
`ifdef CTRL_PERF_CNT_EN
        check("b10_cyc", cyc_cnt, 32'd40);
        check("b10_instret", instret_cnt, 32'd10);
`else
        check("b10_cyc_tied", cyc_cnt, 32'd0);
        check("b10_instret_tied", instret_cnt, 32'd0);
`endif

        reset_dut();
        run_burst("b3", 3);
        step(4);
        check("b3_stays_idle", 32'(state_o), 32'd0);
`ifdef CTRL_PERF_CNT_EN
        check("b3_cyc", cyc_cnt, 32'd12);
        check("b3_instret", instret_cnt, 32'd3);
`else
        check("b3_instret_tied", instret_cnt, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
